// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises a local Fibonacci LFSR to the received
// stream, declares lock after a run of matches and counts bit errors while locked.
module prbs_checker #(
  parameter int            N           = 16,
  parameter logic [N-1:0]  TAPS        = 16'b0000_0000_0010_1100,
  parameter int            LOCK_GOOD   = 32,
  parameter int            LOSS_THRESH = 8
) (
  input  logic        CLK,
  input  logic        n_RESET,
  // din is consumed only on cycles with din_valid=1; there is no backpressure,
  // so every valid bit is taken the cycle it is presented.
  input  logic        din,
  input  logic        din_valid,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int             FW        = $clog2(N + 1);
  localparam logic [N-1:0]   TAP_MASK  = {TAPS[N-1:1], 1'b0};
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [FW-1:0]  FILL_ONE  = FW'(1);
  localparam logic [7:0]     GOOD_LAST = 8'(LOCK_GOOD);
  localparam logic [7:0]     MISS_LAST = 8'(LOSS_THRESH);

  state_t          state_q, state_d;
  logic [N-1:0]    s_q, s_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [7:0]      good_q, good_d;
  logic [7:0]      miss_q, miss_d;
  logic            locked_d, err_d;
  logic [15:0]     err_cnt_d, err_base;
  logic [31:0]     bit_cnt_d, bit_base;

  logic            pred;
  logic            mismatch;
  logic [N-1:0]    shift_din;
  logic [FW-1:0]   fill_inc;
  logic [7:0]      good_inc;
  logic [7:0]      miss_inc;
  logic            cnt_bit;
  logic            cnt_err;

  assign dbg_state = state_q;

  // Prediction is the generator's next feedback bit, i.e. the next stream bit.
  assign pred      = s_q[0] ^ (^(s_q & TAP_MASK));
  assign mismatch  = din ^ pred;
  assign shift_din = {din, s_q[N-1:1]};
  assign fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_ONE;
  assign good_inc  = good_q + 8'd1;
  assign miss_inc  = miss_q + 8'd1;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    fill_d  = fill_q;
    good_d  = good_q;
    miss_d  = miss_q;
    cnt_bit = 1'b0;
    cnt_err = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          s_d    = shift_din;
          fill_d = fill_inc;
          if (fill_inc == FILL_FULL && |shift_din) begin
            state_d = VERIFY;
            good_d  = '0;
          end
        end

        VERIFY: begin
          s_d = shift_din;
          if (!mismatch) begin
            good_d = good_inc;
            if (good_inc == GOOD_LAST) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            state_d = HUNT;
            fill_d  = '0;
            good_d  = '0;
          end
        end

        LOCKED: begin
          // Free-run on the prediction so a corrupted bit never enters s.
          s_d     = {pred, s_q[N-1:1]};
          cnt_bit = 1'b1;
          if (mismatch) begin
            cnt_err = 1'b1;
            miss_d  = miss_inc;
            if (miss_inc == MISS_LAST) begin
              state_d = HUNT;
              fill_d  = '0;
              good_d  = '0;
              miss_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: begin
          state_d = HUNT;
          fill_d  = '0;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // A clear and a same-cycle count event combine to a count of one.
  always_comb begin
    err_base  = clr_cnt ? 16'd0 : err_cnt;
    bit_base  = clr_cnt ? 32'd0 : bit_cnt;
    err_cnt_d = (cnt_err && err_base != 16'hFFFF) ? err_base + 16'd1 : err_base;
    bit_cnt_d = (cnt_bit && bit_base != 32'hFFFF_FFFF) ? bit_base + 32'd1 : bit_base;
    err_d     = cnt_err;
    locked_d  = (state_d == LOCKED);
  end

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state_q <= HUNT;
      s_q     <= '0;
      fill_q  <= '0;
      good_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fill_q  <= fill_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      locked  <= locked_d;
      err     <= err_d;
      err_cnt <= err_cnt_d;
      bit_cnt <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: transmitter LFSR, history-based reference model,
// directed steps plus randomised gaps and error injection.
module tb_prbs_checker;

  localparam int          N           = 16;
  localparam logic [15:0] TAPS        = 16'b0000_0000_0010_1100;
  localparam int          LOCK_GOOD   = 32;
  localparam int          LOSS_THRESH = 8;
  localparam int          W           = 50;

  logic        CLK = 1'b0;
  logic        n_RESET;
  logic        din;
  logic        din_valid;
  logic        clr_cnt;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;
  logic [1:0]  dbg_state;

  prbs_checker #(
    .N(N), .TAPS(TAPS), .LOCK_GOOD(LOCK_GOOD), .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .CLK(CLK), .n_RESET(n_RESET), .din(din), .din_valid(din_valid),
    .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_cnt(err_cnt),
    .bit_cnt(bit_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // transmitter
  logic [15:0] gen;

  function automatic logic gen_next();
    logic b;
    logic fb;
    b  = gen[0];
    fb = gen[0];
    for (int i = 1; i < N; i++) if (TAPS[i]) fb ^= gen[i];
    gen = {fb, gen[15:1]};
    return b;
  endfunction

  // reference model: last N reference bits, oldest first
  bit     hist[$];
  int     m_mode;      // 0 hunting, 1 verifying, 2 locked
  int     m_good;
  int     m_miss;
  int     m_errc;
  longint m_bitc;
  logic   m_err;
  logic   m_locked;
  logic [W-1:0] exp_q[$];

  function automatic bit predict();
    bit p;
    p = hist[0];
    for (int i = 1; i < N; i++) if (TAPS[i]) p ^= hist[i];
    return p;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_mode = 0; m_good = 0; m_miss = 0;
    m_errc = 0; m_bitc = 0; m_err = 1'b0; m_locked = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic d, input logic c);
    bit p;
    int ones;
    m_err = 1'b0;
    if (c) begin
      m_errc = 0;
      m_bitc = 0;
    end
    if (v) begin
      if (m_mode == 0) begin
        hist.push_back(d);
        if (hist.size() > N) void'(hist.pop_front());
        ones = 0;
        foreach (hist[i]) if (hist[i]) ones++;
        if (hist.size() == N && ones > 0) begin
          m_mode = 1;
          m_good = 0;
        end
      end else if (m_mode == 1) begin
        p = predict();
        if (d == p) begin
          hist.push_back(d);
          void'(hist.pop_front());
          m_good++;
          if (m_good == LOCK_GOOD) begin
            m_mode = 2;
            m_miss = 0;
          end
        end else begin
          m_mode = 0;
          hist.delete();
          m_good = 0;
        end
      end else begin
        p = predict();
        hist.push_back(p);
        void'(hist.pop_front());
        if (m_bitc < 64'hFFFF_FFFF) m_bitc++;
        if (d != p) begin
          m_err = 1'b1;
          if (m_errc < 65535) m_errc++;
          m_miss++;
          if (m_miss == LOSS_THRESH) begin
            m_mode = 0;
            hist.delete();
            m_miss = 0;
            m_good = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    m_locked = (m_mode == 2);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic d, input logic c);
    logic [W-1:0] e;
    din_valid = v;
    din       = d;
    clr_cnt   = c;
    @(posedge CLK);
    #1;
    model_step(v, d, c);
    exp_q.push_back({m_locked, m_err, m_errc[15:0], m_bitc[31:0]});
    e = exp_q.pop_front();
    check("locked", {31'd0, locked}, {31'd0, e[49]});
    check("err", {31'd0, err}, {31'd0, e[48]});
    check("err_cnt", {16'd0, err_cnt}, {16'd0, e[47:32]});
    check("bit_cnt", bit_cnt, e[31:0]);
  endtask

  task automatic send(input logic inv, input logic c);
    logic b;
    b = gen_next();
    drive(1'b1, b ^ inv, c);
  endtask

  task automatic gap();
    drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    n_RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    n_RESET = 1'b1;
  endtask

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int vcount;
    int errs;
    n_RESET = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    model_reset();
    #1 n_RESET = 1'b0;
    #2;
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_bit_cnt", bit_cnt, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge CLK);
    n_RESET = 1'b1;

    // clean lock from the all-ones seed
    gen = 16'hFFFF;
    repeat (47) send(1'b0, 1'b0);
    check("lock_47", {31'd0, locked}, 32'd0);
    send(1'b0, 1'b0);
    check("lock_48", {31'd0, locked}, 32'd1);
    check("lock_err_cnt", {16'd0, err_cnt}, 32'd0);
    repeat (10) send(1'b0, 1'b0);
    check("lock_bit_cnt", bit_cnt, 32'd10);

    // single corrupted bit
    send(1'b1, 1'b0);
    check("single_err", {31'd0, err}, 32'd1);
    check("single_err_cnt", {16'd0, err_cnt}, 32'd1);
    check("single_locked", {31'd0, locked}, 32'd1);
    repeat (20) send(1'b0, 1'b0);
    check("single_after", {16'd0, err_cnt}, 32'd1);

    // loss of lock after LOSS_THRESH misses, then re-lock
    send(1'b0, 1'b1);
    check("clr_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("clr_bit_cnt", bit_cnt, 32'd1);
    repeat (7) send(1'b1, 1'b0);
    check("loss_7", {31'd0, locked}, 32'd1);
    send(1'b1, 1'b0);
    check("loss_8", {31'd0, locked}, 32'd0);
    check("loss_err_cnt", {16'd0, err_cnt}, 32'd8);
    repeat (47) send(1'b0, 1'b0);
    check("relock_47", {31'd0, locked}, 32'd0);
    send(1'b0, 1'b0);
    check("relock_48", {31'd0, locked}, 32'd1);

    // random gaps and sparse random errors
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) gap();
      else send(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 99) == 0));
    end

    // all-zero stream keeps hunting
    do_reset();
    repeat (40) drive(1'b1, 1'b0, 1'b0);
    check("zero_state", {30'd0, dbg_state}, 32'd0);
    check("zero_locked", {31'd0, locked}, 32'd0);
    gen = 16'hFFFF;
    vcount = 0;
    while (!m_locked && vcount < 300) begin
      send(1'b0, 1'b0);
      vcount++;
    end
    check("zero_then_lock", {31'd0, locked}, 32'd1);

    // lock count in valid bits is unaffected by gaps
    do_reset();
    gen = 16'hACE1;
    vcount = 0;
    while (vcount < 47) begin
      if ($urandom_range(0, 2) == 0) gap();
      else begin
        send(1'b0, 1'b0);
        vcount++;
      end
    end
    check("gap_47", {31'd0, locked}, 32'd0);
    repeat (3) gap();
    check("gap_hold", {31'd0, locked}, 32'd0);
    send(1'b0, 1'b0);
    check("gap_48", {31'd0, locked}, 32'd1);

    // asynchronous reset between edges while locked
    repeat (5) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    #2 n_RESET = 1'b0;
    #1;
    check("async_locked", {31'd0, locked}, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    check("async_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("async_bit_cnt", bit_cnt, 32'd0);
    model_reset();
    #1 n_RESET = 1'b1;
    repeat (47) send(1'b0, 1'b0);
    check("reacq_47", {31'd0, locked}, 32'd0);
    send(1'b0, 1'b0);
    check("reacq_48", {31'd0, locked}, 32'd1);

    // err_cnt saturation: bursts of LOSS_THRESH-1 errors keep lock
    errs = 0;
    while (errs < 65540) begin
      for (int k = 0; k < LOSS_THRESH - 1 && errs < 65540; k++) begin
        send(1'b1, 1'b0);
        errs++;
      end
      send(1'b0, 1'b0);
    end
    check("sat_err_cnt", {16'd0, err_cnt}, 32'h0000_FFFF);
    check("sat_locked", {31'd0, locked}, 32'd1);
    send(1'b1, 1'b1);
    check("clr_with_err", {16'd0, err_cnt}, 32'd1);
    check("clr_with_bit", bit_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter N, default 16, meaning LFSR length in bits, legal range 2..32.
REQ-002 Parameter TAPS, default 16'b0000_0000_0010_1100, meaning feedback tap mask over s[N-1:1]; s[0] is always in the feedback.
REQ-003 Parameter LOCK_GOOD, default 32, meaning consecutive matching bits required to declare lock, range 1..255.
REQ-004 Parameter LOSS_THRESH, default 8, meaning consecutive mismatches that drop lock, range 1..255.
REQ-005 Port CLK, input, 1 bit, sole clock, rising edge.
REQ-006 Port n_RESET, input, 1 bit, asynchronous active-low reset.
REQ-007 Port din, input, 1 bit, received serial PRBS bit.
REQ-008 Port din_valid, input, 1 bit, din qualifier; all state holds when low.
REQ-009 Port clr_cnt, input, 1 bit, synchronous clear of err_cnt and bit_cnt.
REQ-010 Port locked, output, 1 bit, registered lock indicator.
REQ-011 Port err, output, 1 bit, registered one-cycle pulse per mismatch counted while locked.
REQ-012 Port err_cnt, output, 16 bits, saturating count of mismatches while locked.
REQ-013 Port bit_cnt, output, 32 bits, saturating count of bits compared while locked.

Function
REQ-014 The checker SHALL model the team's Fibonacci generator: state s[N-1:0], transmitted bit = s[0], next state = {fb, s[N-1:1]}, fb = s[0] XOR s[i] for every i with TAPS[i]=1.
REQ-015 The prediction for each incoming bit SHALL be fb computed on the current checker register s.
REQ-016 The FSM SHALL have the states HUNT, VERIFY and LOCKED, and SHALL advance only on cycles with din_valid=1.
REQ-017 HUNT: s <= {din, s[N-1:1]}; fill counter increments and saturates at N; no comparison and no counting.
REQ-018 HUNT->VERIFY SHALL occur on the valid bit where the fill count reaches or already equals N and the updated s is non-zero; an all-zero s SHALL keep the FSM in HUNT.
REQ-019 VERIFY: din SHALL be compared against the prediction; on a match s shifts in din and the good counter increments; on a mismatch the FSM goes to HUNT with the fill and good counters cleared.
REQ-020 VERIFY->LOCKED SHALL occur on the LOCK_GOOD-th consecutive match, and locked SHALL be 1 from the following cycle.
REQ-021 LOCKED: s SHALL shift in the predicted bit, not din, so that one corrupted bit yields exactly one error.
REQ-022 LOCKED, each valid bit: bit_cnt +1; on a mismatch, err is pulsed the next cycle, err_cnt +1 and the consecutive-miss counter +1; a match clears the miss counter.
REQ-023 When the miss counter reaches LOSS_THRESH, the FSM SHALL go to HUNT, clear locked the next cycle, clear the fill, good and miss counters, and keep the counter values.
REQ-024 err_cnt SHALL saturate at 16'hFFFF and bit_cnt SHALL saturate at 32'hFFFF_FFFF, with no wrap.
REQ-025 clr_cnt=1 SHALL zero both counters, but a same-cycle count event SHALL still apply after the clear (result 1).
REQ-026 clr_cnt SHALL NOT affect the FSM, s, or locked.
REQ-027 With din_valid=0, s, the FSM, all counters and locked SHALL hold, and err SHALL be 0.

Reset
REQ-028 n_RESET=0 SHALL immediately force: FSM=HUNT, s=0, fill/good/miss counters=0, locked=0, err=0, err_cnt=0, bit_cnt=0, regardless of CLK.
REQ-029 A reset asserted mid-lock SHALL discard lock, and re-acquisition SHALL require the full N + LOCK_GOOD valid bits.

Verification
REQ-030 Lock: drive the N=16 generator from the all-ones seed with din_valid held at 1 -> locked=1 in the cycle after the 48th valid bit, err_cnt=0, and bit_cnt increments by 1 per bit thereafter.
REQ-031 Single error: when locked, invert one bit -> one err pulse, err_cnt=1, locked stays 1, and following bits give no further errors.
REQ-032 Loss: when locked, invert 8 consecutive bits -> err_cnt=8, locked=0 the cycle after the 8th, and clean stream afterwards re-locks after 48 more valid bits.
REQ-033 Zero stream: 40 zero bits after reset -> FSM stays in HUNT and locked=0; a following valid PRBS stream locks normally.
REQ-034 Counters: preload via 65540 inverted-pattern errors (re-locking as needed) -> err_cnt=16'hFFFF; clr_cnt together with a mismatch -> err_cnt=1.
REQ-035 Gaps/reset: random din_valid=0 gaps -> same lock cycle count in valid bits; pulse n_RESET low between edges while locked -> all outputs 0 immediately.
